// File: rtl/ray_gen_if.sv
// Ray direction bus between the camera ray generator and its consumer.
// Carries one {x,y,z} double-precision direction plus its pixel coordinates.
interface ray_gen_if #(
  parameter int WIDTH  = 200,
  parameter int HEIGHT = 100
);
  localparam int XW = $clog2(WIDTH) + 1;
  localparam int YW = $clog2(HEIGHT) + 1;

  logic          dir_valid;
  logic          dir_ready;
  logic [191:0]  dir;
  logic [XW-1:0] px_x;
  logic [YW-1:0] px_y;

  modport master (
    output dir_valid,
    output dir,
    output px_x,
    output px_y,
    input  dir_ready
  );

  modport slave (
    input  dir_valid,
    input  dir,
    input  px_x,
    input  px_y,
    output dir_ready
  );
endinterface

// File: rtl/ray_gen.sv
// Camera ray generator: scans a WIDTH x HEIGHT frame top row first and emits
// one double-precision ray direction per pixel over a valid/ready bus.
//
// state | meaning
// IDLE  | waiting for start, no ray presented
// EMIT  | current pixel's ray presented, advance on each transfer
// DONE  | one-cycle completion pulse, then back to IDLE
module ray_gen #(
  parameter int WIDTH  = 200,
  parameter int HEIGHT = 100
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      start,
  output logic      busy,
  output logic      done,
  ray_gen_if.master ray
);
  localparam int XW = $clog2(WIDTH) + 1;
  localparam int YW = $clog2(HEIGHT) + 1;
  localparam logic [63:0] DIR_Z = 64'hBFF0000000000000;

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t        state, state_nxt;
  logic [XW-1:0] px_x_q, px_x_nxt;
  logic [YW-1:0] px_y_q, px_y_nxt;
  logic [63:0]   dir_x_q, dir_y_q, dir_z_q;
  logic          load;
  logic          xfer;
  logic          last_px;

  logic [63:0]   x_rom [2**XW];
  logic [63:0]   y_rom [2**YW];

  // Both coordinates are evaluated exactly as double arithmetic would do it
  // (u rounded first, then scaled and offset), folded into per-index tables.
  function automatic logic [63:0] x_dir(input int i);
    real u;
    u = real'(i) / real'(WIDTH);
    return $realtobits(-2.0 + 4.0 * u);
  endfunction

  function automatic logic [63:0] y_dir(input int j);
    real v;
    v = real'(j) / real'(HEIGHT);
    return $realtobits(-1.0 + 2.0 * v);
  endfunction

  for (genvar g = 0; g < 2**XW; g++) begin : g_xrom
    if (g < WIDTH) begin : g_on
      assign x_rom[g] = x_dir(g);
    end else begin : g_off
      assign x_rom[g] = '0;
    end
  end

  for (genvar g = 0; g < 2**YW; g++) begin : g_yrom
    if (g < HEIGHT) begin : g_on
      assign y_rom[g] = y_dir(g);
    end else begin : g_off
      assign y_rom[g] = '0;
    end
  end

  assign xfer    = (state == EMIT) && ray.dir_ready;
  assign last_px = (px_x_q == XW'(WIDTH - 1)) && (px_y_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    px_x_nxt  = px_x_q;
    px_y_nxt  = px_y_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = EMIT;
          load      = 1'b1;
          px_x_nxt  = '0;
          px_y_nxt  = YW'(HEIGHT - 1);
        end
      end
      EMIT: begin
        if (xfer) begin
          if (last_px) begin
            state_nxt = DONE;
          end else begin
            load = 1'b1;
            if (px_x_q == XW'(WIDTH - 1)) begin
              px_x_nxt = '0;
              px_y_nxt = px_y_q - 1'b1;
            end else begin
              px_x_nxt = px_x_q + 1'b1;
            end
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Coordinates and direction load together so a held ray never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_x_q  <= '0;
      px_y_q  <= '0;
      dir_x_q <= '0;
      dir_y_q <= '0;
      dir_z_q <= '0;
    end else if (load) begin
      px_x_q  <= px_x_nxt;
      px_y_q  <= px_y_nxt;
      dir_x_q <= x_rom[px_x_nxt];
      dir_y_q <= y_rom[px_y_nxt];
      dir_z_q <= DIR_Z;
    end
  end

  assign busy          = (state == EMIT) || (state == DONE);
  assign done          = (state == DONE);
  assign ray.dir_valid = (state == EMIT);
  assign ray.dir       = {dir_x_q, dir_y_q, dir_z_q};
  assign ray.px_x      = px_x_q;
  assign ray.px_y      = px_y_q;
endmodule

// File: tb/tb_ray_gen.sv
// Self-checking bench for ray_gen on a 4x2 frame: scoreboard of expected rays,
// handshake stability monitor, latency, backpressure, ignored start and reset abort.
module tb_ray_gen;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int XW = $clog2(W) + 1;
  localparam int YW = $clog2(H) + 1;
  localparam logic [191:0] FIRST_DIR = {64'hC000000000000000, 64'h0000000000000000, 64'hBFF0000000000000};
  localparam logic [191:0] LAST_DIR  = {64'h3FF0000000000000, 64'hBFF0000000000000, 64'hBFF0000000000000};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;

  always #5 clk = ~clk;

  ray_gen_if #(.WIDTH(W), .HEIGHT(H)) ray_bus ();

  ray_gen #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .ray   (ray_bus)
  );

  int n_cmp  = 0;
  int n_err  = 0;
  int n_xfer = 0;
  int n_done = 0;
  logic [191:0] last_dir = '0;
  logic [XW+YW+191:0] exp_q[$];

  task automatic chk(input string tag, input logic [XW+YW+191:0] obs, input logic [XW+YW+191:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // For a 4x2 frame every coordinate is exact: x = i-2, y = j-1, z = -1.
  function automatic logic [191:0] model_dir(input int i, input int j);
    return {$realtobits($itor(i) - 2.0), $realtobits($itor(j) - 1.0), 64'hBFF0000000000000};
  endfunction

  function automatic logic [XW+YW+191:0] cur_ray();
    return {ray_bus.px_x, ray_bus.px_y, ray_bus.dir};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    for (int j = H - 1; j >= 0; j--)
      for (int i = 0; i < W; i++)
        exp_q.push_back({XW'(i), YW'(j), model_dir(i, j)});
  endtask

  task automatic start_frame();
    start = 1'b1;
    push_frame();
    tick();
    start = 1'b0;
    chk("first_valid", 1'(ray_bus.dir_valid), 1'b1);
    chk("first_busy", 1'(busy), 1'b1);
    chk("first_ray", cur_ray(), {XW'(0), YW'(1), FIRST_DIR});
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("done_timeout", 1'(done), 1'b1);
  endtask

  // Monitor: pops the scoreboard on every transfer and checks that a stalled ray holds.
  initial begin
    logic stall = 1'b0;
    logic [XW+YW+191:0] snap = '0;
    logic [XW+YW+191:0] cur;
    logic [XW+YW+191:0] e;
    forever begin
      @(negedge clk);
      cur = cur_ray();
      if (done) n_done++;
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("hold_valid", 1'(ray_bus.dir_valid), 1'b1);
          chk("hold_data", cur, snap);
        end
        if (ray_bus.dir_valid && ray_bus.dir_ready) begin
          n_xfer++;
          if (exp_q.size() == 0) begin
            chk("unexpected_ray", cur, '0);
          end else begin
            e = exp_q.pop_front();
            chk("ray", cur, e);
            last_dir = ray_bus.dir;
          end
        end
        stall = ray_bus.dir_valid && !ray_bus.dir_ready;
        snap  = cur;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int bx;
    int bd;
    int k;
    logic [XW+YW+191:0] snap;

    ray_bus.dir_ready = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 1'(busy), 1'b0);
    chk("rst_done", 1'(done), 1'b0);
    chk("rst_valid", 1'(ray_bus.dir_valid), 1'b0);
    chk("rst_ray", cur_ray(), '0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_valid", 1'(ray_bus.dir_valid), 1'b0);

    // Full frame with the consumer always ready
    ray_bus.dir_ready = 1'b1;
    bx = n_xfer;
    bd = n_done;
    start_frame();
    wait_done(lat);
    chk("done_latency", 32'(lat), 32'd9);
    chk("done_busy", 1'(busy), 1'b1);
    chk("done_valid", 1'(ray_bus.dir_valid), 1'b0);
    tick();
    chk("done_width", 1'(done), 1'b0);
    chk("busy_after", 1'(busy), 1'b0);
    chk("frame_xfers", 32'(n_xfer - bx), 32'd8);
    chk("last_dir", last_dir, LAST_DIR);
    chk("frame_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("frame_done_count", 32'(n_done - bd), 32'd1);

    // Backpressure mid-frame
    bx = n_xfer;
    bd = n_done;
    start_frame();
    tick();
    ray_bus.dir_ready = 1'b0;
    tick();
    snap = cur_ray();
    tick();
    tick();
    chk("bp_hold", cur_ray(), snap);
    chk("bp_valid", 1'(ray_bus.dir_valid), 1'b1);
    ray_bus.dir_ready = 1'b1;
    wait_done(lat);
    tick();
    chk("bp_xfers", 32'(n_xfer - bx), 32'd8);
    chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("bp_done_count", 32'(n_done - bd), 32'd1);

    // Start ignored in EMIT and in DONE, accepted in the following IDLE cycle
    bx = n_xfer;
    bd = n_done;
    start_frame();
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat);
    chk("ign_done_seen", 1'(done), 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_done_start_valid", 1'(ray_bus.dir_valid), 1'b0);
    chk("ign_done_start_busy", 1'(busy), 1'b0);
    start_frame();
    wait_done(lat);
    chk("restart_latency", 32'(lat), 32'd9);
    tick();
    chk("ign_xfers", 32'(n_xfer - bx), 32'd16);
    chk("ign_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("ign_done_count", 32'(n_done - bd), 32'd2);

    // Asynchronous reset after three transfers aborts the frame
    bx = n_xfer;
    start_frame();
    k = 0;
    while ((n_xfer - bx) < 3 && k < 50) begin
      tick();
      k++;
    end
    chk("pre_reset_xfers", 32'(n_xfer - bx), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 1'(ray_bus.dir_valid), 1'b0);
    chk("async_busy", 1'(busy), 1'b0);
    chk("async_done", 1'(done), 1'b0);
    chk("async_ray", cur_ray(), '0);
    exp_q.delete();
    bd = n_done;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("abort_idle_valid", 1'(ray_bus.dir_valid), 1'b0);
    chk("abort_no_done", 32'(n_done - bd), 32'd0);
    bx = n_xfer;
    start_frame();
    wait_done(lat);
    tick();
    chk("post_reset_xfers", 32'(n_xfer - bx), 32'd8);
    chk("post_reset_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("post_reset_done_count", 32'(n_done - bd), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
